// File: rtl/fu_md_pkg.sv
// -----------------------------------------------------------------------------
// fu_md_pkg
// Shared types for the RV32M multiply/divide functional unit.
//   md_opcode_t : 3-bit uop opcode as issued by the integer reservation station
//   fu_md_reg_t : the uop fields held by the unit while it is in flight
// The tag widths below are the widths the fu_md parameters default to.
// -----------------------------------------------------------------------------
package fu_md_pkg;

    localparam int ROB_IDX_W = 5;
    localparam int PRF_IDX_W = 6;
    localparam int ARF_IDX_W = 5;
    localparam int XLEN      = 32;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } md_opcode_t;

    typedef struct packed {
        logic [ROB_IDX_W-1:0] rob_id;
        logic [PRF_IDX_W-1:0] rd_phy;
        logic [ARF_IDX_W-1:0] rd_arch;
        md_opcode_t           fu_opcode;
        logic [XLEN-1:0]      rs1_value;
        logic [XLEN-1:0]      rs2_value;
    } fu_md_reg_t;

    function automatic logic is_div_op(md_opcode_t op);
        return (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
    endfunction

    function automatic logic is_signed_div(md_opcode_t op);
        return (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic is_rem_op(md_opcode_t op);
        return (op == OP_REM) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/md_divider_step.sv
// -----------------------------------------------------------------------------
// md_divider_step
// One combinational step of unsigned restoring division.
//   rem_in   : partial remainder from the previous step (always < divisor)
//   dvd_bit  : next dividend bit, MSB first
//   divisor  : unsigned divisor (non-zero)
//   rem_out  : partial remainder after the step
//   q_bit    : quotient bit produced by the step
// -----------------------------------------------------------------------------
module md_divider_step (
    input  logic [31:0] rem_in,
    input  logic        dvd_bit,
    input  logic [31:0] divisor,
    output logic [31:0] rem_out,
    output logic        q_bit
);

    logic [32:0] shifted;
    logic [32:0] diff;

    // Because rem_in < divisor, the shifted value is < 2*divisor: a successful
    // subtraction always leaves bit 32 clear, and a failed one always wraps
    // with bit 32 set, so bit 32 of the difference acts as the borrow.
    always_comb begin
        shifted = {rem_in, dvd_bit};
        diff    = shifted - {1'b0, divisor};
        q_bit   = ~diff[32];
        rem_out = q_bit ? diff[31:0] : shifted[31:0];
    end

endmodule

// File: rtl/fu_md.sv
// -----------------------------------------------------------------------------
// fu_md
// RV32M integer multiply/divide functional unit. One uop in flight at a time.
// Multiplies finish in a fixed two cycles, divides iterate 32 restoring steps,
// divide-by-zero and signed overflow are resolved at accept. Each result is
// broadcast on the CDB for exactly one cycle.
// Ports:
//   clk, rst (synchronous, active-low)
//   md_rs_valid / fu_md_ready        : issue handshake
//   rob_id, rd_phy, rd_arch          : uop tags
//   fu_opcode, rs1_value, rs2_value  : operation and operands
//   cdb_valid, cdb_rob_id, cdb_rd_phy, cdb_rd_arch, cdb_rd_value : broadcast
// -----------------------------------------------------------------------------
module fu_md
    import fu_md_pkg::*;
#(
    parameter int ROB_IDX = ROB_IDX_W,
    parameter int PRF_IDX = PRF_IDX_W,
    parameter int ARF_IDX = ARF_IDX_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               md_rs_valid,
    output logic               fu_md_ready,
    input  logic [ROB_IDX-1:0] rob_id,
    input  logic [PRF_IDX-1:0] rd_phy,
    input  logic [ARF_IDX-1:0] rd_arch,
    input  logic [2:0]         fu_opcode,
    input  logic [31:0]        rs1_value,
    input  logic [31:0]        rs2_value,
    output logic               cdb_valid,
    output logic [ROB_IDX-1:0] cdb_rob_id,
    output logic [PRF_IDX-1:0] cdb_rd_phy,
    output logic [ARF_IDX-1:0] cdb_rd_arch,
    output logic [31:0]        cdb_rd_value
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } fu_md_state_t;

    fu_md_state_t state_q, state_d;
    logic [4:0]   step_cnt;
    fu_md_reg_t   uop_q;

    logic [31:0]  rem_q;   // partial remainder
    logic [31:0]  dvd_q;   // dividend shifts out MSB-first, quotient shifts in LSB
    logic [31:0]  dvs_q;   // magnitude of the divisor

    logic [31:0]  step_rem;
    logic         step_qbit;

    function automatic logic [31:0] abs_val(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? (32'd0 - v) : v;
    endfunction

    function automatic logic [31:0] neg_if(input logic [31:0] v, input logic neg);
        return neg ? (32'd0 - v) : v;
    endfunction

    // ---------------- issue-side decode ----------------
    md_opcode_t  op_in;
    logic        accept;
    logic        in_div, in_signed, in_rem;
    logic        special;
    logic [31:0] special_value;

    always_comb begin
        op_in     = md_opcode_t'(fu_opcode);
        accept    = md_rs_valid && fu_md_ready;
        in_div    = is_div_op(op_in);
        in_signed = is_signed_div(op_in);
        in_rem    = is_rem_op(op_in);
        special   = 1'b0;
        special_value = '0;
        if (in_div) begin
            if (rs2_value == 32'd0) begin
                special       = 1'b1;
                special_value = in_rem ? rs1_value : 32'hFFFF_FFFF;
            end else if (in_signed && rs1_value == 32'h8000_0000 && rs2_value == 32'hFFFF_FFFF) begin
                special       = 1'b1;
                special_value = in_rem ? 32'd0 : 32'h8000_0000;
            end
        end
    end

    // ---------------- multiply datapath ----------------
    // The 33-bit sign/zero-extended operands are widened to 64 bits; the low
    // 64 bits of that product equal the 66-bit product truncated to 64 bits.
    logic signed [63:0] mul_a, mul_b, mul_prod;
    logic [31:0]        mul_result;
    logic               a_sgn, b_sgn;

    always_comb begin
        a_sgn = (uop_q.fu_opcode != OP_MULHU);
        b_sgn = (uop_q.fu_opcode == OP_MUL) || (uop_q.fu_opcode == OP_MULH);
        mul_a = a_sgn ? {{32{uop_q.rs1_value[31]}}, uop_q.rs1_value} : {32'd0, uop_q.rs1_value};
        mul_b = b_sgn ? {{32{uop_q.rs2_value[31]}}, uop_q.rs2_value} : {32'd0, uop_q.rs2_value};
        mul_prod   = mul_a * mul_b;
        mul_result = (uop_q.fu_opcode == OP_MUL) ? mul_prod[31:0] : mul_prod[63:32];
    end

    // ---------------- divide datapath ----------------
    md_divider_step u_step (
        .rem_in  (rem_q),
        .dvd_bit (dvd_q[31]),
        .divisor (dvs_q),
        .rem_out (step_rem),
        .q_bit   (step_qbit)
    );

    logic [31:0] div_result;
    logic        q_neg, r_neg;

    // Sign fix-up applied to the final step's outputs as the FSM enters DONE.
    always_comb begin
        q_neg = is_signed_div(uop_q.fu_opcode) && (uop_q.rs1_value[31] ^ uop_q.rs2_value[31]);
        r_neg = is_signed_div(uop_q.fu_opcode) && uop_q.rs1_value[31];
        div_result = is_rem_op(uop_q.fu_opcode) ? neg_if(step_rem, r_neg)
                                                : neg_if({dvd_q[30:0], step_qbit}, q_neg);
    end

    // ---------------- FSM next state ----------------
    logic load_cdb;

    always_comb begin
        state_d  = state_q;
        load_cdb = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (!in_div) begin
                        state_d = ST_MUL;
                    end else if (special) begin
                        state_d  = ST_DONE;
                        load_cdb = 1'b1;
                    end else begin
                        state_d = ST_DIV;
                    end
                end
            end
            ST_MUL: begin
                state_d  = ST_DONE;
                load_cdb = 1'b1;
            end
            ST_DIV: begin
                if (step_cnt == 5'd31) begin
                    state_d  = ST_DONE;
                    load_cdb = 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign fu_md_ready = (state_q == ST_IDLE);
    assign cdb_valid   = (state_q == ST_DONE);

    // ---------------- control registers ----------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            step_cnt     <= 5'd0;
            cdb_rob_id   <= '0;
            cdb_rd_phy   <= '0;
            cdb_rd_arch  <= '0;
            cdb_rd_value <= '0;
        end else begin
            state_q  <= state_d;
            step_cnt <= (state_q == ST_DIV) ? step_cnt + 5'd1 : 5'd0;
            if (load_cdb) begin
                if (state_q == ST_IDLE) begin
                    // special case: result and tags straight from the issue port
                    cdb_rob_id   <= rob_id;
                    cdb_rd_phy   <= rd_phy;
                    cdb_rd_arch  <= rd_arch;
                    cdb_rd_value <= special_value;
                end else begin
                    cdb_rob_id   <= uop_q.rob_id;
                    cdb_rd_phy   <= uop_q.rd_phy;
                    cdb_rd_arch  <= uop_q.rd_arch;
                    cdb_rd_value <= (state_q == ST_MUL) ? mul_result : div_result;
                end
            end
        end
    end

    // ---------------- data registers ----------------
    always_ff @(posedge clk) begin
        if (accept) begin
            uop_q.rob_id    <= rob_id;
            uop_q.rd_phy    <= rd_phy;
            uop_q.rd_arch   <= rd_arch;
            uop_q.fu_opcode <= op_in;
            uop_q.rs1_value <= rs1_value;
            uop_q.rs2_value <= rs2_value;
            rem_q           <= 32'd0;
            dvd_q           <= abs_val(rs1_value, in_signed);
            dvs_q           <= abs_val(rs2_value, in_signed);
        end else if (state_q == ST_DIV) begin
            rem_q <= step_rem;
            dvd_q <= {dvd_q[30:0], step_qbit};
        end
    end

endmodule

// File: tb/tb_fu_md.sv
module tb_fu_md;

    logic        clk = 1'b0;
    logic        rst;
    logic        md_rs_valid;
    logic        fu_md_ready;
    logic [4:0]  rob_id;
    logic [5:0]  rd_phy;
    logic [4:0]  rd_arch;
    logic [2:0]  fu_opcode;
    logic [31:0] rs1_value;
    logic [31:0] rs2_value;
    logic        cdb_valid;
    logic [4:0]  cdb_rob_id;
    logic [5:0]  cdb_rd_phy;
    logic [4:0]  cdb_rd_arch;
    logic [31:0] cdb_rd_value;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fu_md dut (
        .clk          (clk),
        .rst          (rst),
        .md_rs_valid  (md_rs_valid),
        .fu_md_ready  (fu_md_ready),
        .rob_id       (rob_id),
        .rd_phy       (rd_phy),
        .rd_arch      (rd_arch),
        .fu_opcode    (fu_opcode),
        .rs1_value    (rs1_value),
        .rs2_value    (rs2_value),
        .cdb_valid    (cdb_valid),
        .cdb_rob_id   (cdb_rob_id),
        .cdb_rd_phy   (cdb_rd_phy),
        .cdb_rd_arch  (cdb_rd_arch),
        .cdb_rd_value (cdb_rd_value)
    );

    task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rob, input logic [5:0] phy, input logic [4:0] arch);
        fu_opcode   = op;
        rs1_value   = a;
        rs2_value   = b;
        rob_id      = rob;
        rd_phy      = phy;
        rd_arch     = arch;
        md_rs_valid = 1'b1;
    endtask

    // Called just after a falling edge while the unit is idle; returns after the accept edge.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rob, input logic [5:0] phy, input logic [4:0] arch);
        drive(op, a, b, rob, phy, arch);
        @(posedge clk);
        #1 md_rs_valid = 1'b0;
    endtask

    // Counts cycles after the accept edge until cdb_valid; -1 if the budget runs out.
    task automatic wait_cdb(input int limit, output int lat);
        lat = -1;
        for (int c = 1; c <= limit; c++) begin
            @(negedge clk);
            if (cdb_valid === 1'b1) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b0;
        drive(3'd0, 32'd3, 32'd4, 5'd1, 6'd2, 5'd3);
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (fu_md_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got %b want 1", fu_md_ready); end
        n_cmp++; if (cdb_valid !== 1'b0) begin n_bad++; $display("FAIL reset_cdb_valid got %b want 0", cdb_valid); end
        n_cmp++; if ({cdb_rob_id, cdb_rd_phy, cdb_rd_arch, cdb_rd_value} !== 48'd0) begin
            n_bad++; $display("FAIL reset_cdb_fields got %h/%h/%h/%h want all 0", cdb_rob_id, cdb_rd_phy, cdb_rd_arch, cdb_rd_value);
        end
        md_rs_valid = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++; if (fu_md_ready !== 1'b1 || cdb_valid !== 1'b0) begin
            n_bad++; $display("FAIL reset_no_accept got ready=%b valid=%b want 1/0", fu_md_ready, cdb_valid);
        end
    endtask

    task automatic test_mul;
        @(negedge clk);
        issue(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd3, 6'd17, 5'd9);
        @(negedge clk);
        n_cmp++; if (fu_md_ready !== 1'b0 || cdb_valid !== 1'b0) begin
            n_bad++; $display("FAIL mul_t1 got ready=%b valid=%b want 0/0", fu_md_ready, cdb_valid);
        end
        @(negedge clk);
        n_cmp++; if (fu_md_ready !== 1'b0 || cdb_valid !== 1'b1) begin
            n_bad++; $display("FAIL mul_t2 got ready=%b valid=%b want 0/1", fu_md_ready, cdb_valid);
        end
        n_cmp++; if (cdb_rd_value !== 32'hFFFF_FFEB) begin n_bad++; $display("FAIL mul_value got %h want ffffffeb", cdb_rd_value); end
        n_cmp++; if (cdb_rob_id !== 5'd3 || cdb_rd_phy !== 6'd17 || cdb_rd_arch !== 5'd9) begin
            n_bad++; $display("FAIL mul_tags got %0d/%0d/%0d want 3/17/9", cdb_rob_id, cdb_rd_phy, cdb_rd_arch);
        end
        @(negedge clk);
        n_cmp++; if (cdb_valid !== 1'b0 || fu_md_ready !== 1'b1) begin
            n_bad++; $display("FAIL mul_t3 got valid=%b ready=%b want 0/1", cdb_valid, fu_md_ready);
        end
    endtask

    task automatic test_mulh;
        int lat;
        logic [31:0] exp_v;
        for (int i = 1; i <= 3; i++) begin
            case (i)
                1: exp_v = 32'hFFFF_FFFF;
                2: exp_v = 32'hFFFF_FFFF;
                default: exp_v = 32'h0000_0001;
            endcase
            @(negedge clk);
            issue(3'(i), 32'hFFFF_FFFF, 32'd2, 5'(i), 6'd40, 5'd1);
            wait_cdb(5, lat);
            n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL mulh_lat op%0d got %0d want 2", i, lat); end
            n_cmp++; if (cdb_rd_value !== exp_v) begin n_bad++; $display("FAIL mulh_value op%0d got %h want %h", i, cdb_rd_value, exp_v); end
        end
    endtask

    task automatic test_div_signed;
        int lat;
        logic [31:0] exp_v;
        for (int i = 0; i < 2; i++) begin
            exp_v = (i == 0) ? 32'hFFFF_FFFD : 32'hFFFF_FFFF;
            @(negedge clk);
            issue((i == 0) ? 3'd4 : 3'd6, 32'hFFFF_FFF9, 32'd2, 5'd20, 6'd21, 5'd22);
            wait_cdb(40, lat);
            n_cmp++; if (lat !== 33) begin n_bad++; $display("FAIL div_lat #%0d got %0d want 33", i, lat); end
            n_cmp++; if (cdb_rd_value !== exp_v) begin n_bad++; $display("FAIL div_value #%0d got %h want %h", i, cdb_rd_value, exp_v); end
            @(negedge clk);
            n_cmp++; if (cdb_valid !== 1'b0) begin n_bad++; $display("FAIL div_one_cycle #%0d got %b want 0", i, cdb_valid); end
        end
    endtask

    task automatic test_special;
        int lat, exp_lat;
        logic [2:0]  op;
        logic [31:0] a, b, exp_v;
        for (int i = 0; i < 7; i++) begin
            case (i)
                0: begin op = 3'd5; a = 32'd5;          b = 32'd0;          exp_v = 32'hFFFF_FFFF; exp_lat = 1;  end
                1: begin op = 3'd6; a = 32'd5;          b = 32'd0;          exp_v = 32'd5;         exp_lat = 1;  end
                2: begin op = 3'd4; a = 32'h8000_0000; b = 32'hFFFF_FFFF; exp_v = 32'h8000_0000; exp_lat = 1;  end
                3: begin op = 3'd6; a = 32'h8000_0000; b = 32'hFFFF_FFFF; exp_v = 32'd0;         exp_lat = 1;  end
                4: begin op = 3'd5; a = 32'd100;        b = 32'd7;          exp_v = 32'd14;        exp_lat = 33; end
                5: begin op = 3'd7; a = 32'd100;        b = 32'd7;          exp_v = 32'd2;         exp_lat = 33; end
                default: begin op = 3'd5; a = 32'hFFFF_FFFF; b = 32'd10;   exp_v = 32'h1999_9999; exp_lat = 33; end
            endcase
            @(negedge clk);
            issue(op, a, b, 5'(i + 8), 6'd5, 5'd6);
            wait_cdb(40, lat);
            n_cmp++; if (lat !== exp_lat) begin n_bad++; $display("FAIL special_lat #%0d got %0d want %0d", i, lat, exp_lat); end
            n_cmp++; if (cdb_rd_value !== exp_v) begin n_bad++; $display("FAIL special_value #%0d got %h want %h", i, cdb_rd_value, exp_v); end
            n_cmp++; if (cdb_rob_id !== 5'(i + 8)) begin n_bad++; $display("FAIL special_rob #%0d got %0d want %0d", i, cdb_rob_id, i + 8); end
        end
    endtask

    task automatic test_back_to_back;
        int lat;
        @(negedge clk);
        drive(3'd4, 32'd100, 32'd7, 5'd1, 6'd11, 5'd12);
        @(posedge clk);
        #1 drive(3'd0, 32'd6, 32'd7, 5'd2, 6'd13, 5'd14);
        wait_cdb(40, lat);
        n_cmp++; if (lat !== 33) begin n_bad++; $display("FAIL b2b_div_lat got %0d want 33", lat); end
        n_cmp++; if (cdb_rd_value !== 32'd14 || cdb_rob_id !== 5'd1) begin
            n_bad++; $display("FAIL b2b_div_result got %h rob %0d want 0000000e rob 1", cdb_rd_value, cdb_rob_id);
        end
        n_cmp++; if (fu_md_ready !== 1'b0) begin n_bad++; $display("FAIL b2b_ready_done got %b want 0", fu_md_ready); end
        @(negedge clk);
        n_cmp++; if (fu_md_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready_idle got %b want 1", fu_md_ready); end
        @(posedge clk);
        #1 md_rs_valid = 1'b0;
        wait_cdb(5, lat);
        n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL b2b_mul_lat got %0d want 2", lat); end
        n_cmp++; if (cdb_rd_value !== 32'd42 || cdb_rob_id !== 5'd2) begin
            n_bad++; $display("FAIL b2b_mul_result got %h rob %0d want 0000002a rob 2", cdb_rd_value, cdb_rob_id);
        end
    endtask

    task automatic test_reset_mid;
        int highs, lat;
        @(negedge clk);
        issue(3'd4, 32'd100, 32'd7, 5'd7, 6'd7, 5'd7);
        repeat (10) @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        n_cmp++; if (fu_md_ready !== 1'b1) begin n_bad++; $display("FAIL rstmid_ready got %b want 1", fu_md_ready); end
        n_cmp++; if (cdb_rd_value !== 32'd0 || cdb_rob_id !== 5'd0) begin
            n_bad++; $display("FAIL rstmid_fields got %h rob %0d want 0 rob 0", cdb_rd_value, cdb_rob_id);
        end
        highs = 0;
        repeat (40) begin
            @(negedge clk);
            if (cdb_valid !== 1'b0) highs++;
        end
        n_cmp++; if (highs !== 0) begin n_bad++; $display("FAIL rstmid_no_cdb got %0d valid cycles want 0", highs); end
        issue(3'd0, 32'd3, 32'd5, 5'd30, 6'd31, 5'd29);
        wait_cdb(5, lat);
        n_cmp++; if (lat !== 2 || cdb_rd_value !== 32'd15) begin
            n_bad++; $display("FAIL rstmid_recover got lat %0d value %h want 2 0000000f", lat, cdb_rd_value);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout got still running want finished");
        $fatal(1, "timeout");
    end

    initial begin
        md_rs_valid = 1'b0;
        fu_opcode   = 3'd0;
        rs1_value   = 32'd0;
        rs2_value   = 32'd0;
        rob_id      = 5'd0;
        rd_phy      = 6'd0;
        rd_arch     = 5'd0;
        test_reset();
        test_mul();
        test_mulh();
        test_div_signed();
        test_special();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
